player_compositor: RTL and testbench

//  Downstream of Background. Owns the player's maze position and overlays a 32x32 player

---
 rtl/player_compositor_pkg.sv | 58 +++++
 rtl/player_rom.sv | 20 ++
 rtl/player_compositor.sv | 224 ++++++++++++++++++++++
 tb/tb_player_compositor.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/player_compositor_pkg.sv
// Shared definitions for the player compositor: maze geometry, the wall map,
// direction/state encodings and the sprite texel generator used by the ROM.
package player_compositor_pkg;

  localparam int MAZE_W = 20;
  localparam int MAZE_H = 15;
  localparam int TILE   = 32;
  localparam int H_VIS0 = 144;
  localparam int V_VIS0 = 31;
  localparam int H_VIS1 = 783;
  localparam int V_VIS1 = 510;

  localparam logic [7:0] SPRITE_KEY = 8'hE3;

  typedef enum logic [1:0] {
    DIR_UP = 2'd0,
    DIR_DN = 2'd1,
    DIR_LT = 2'd2,
    DIR_RT = 2'd3
  } dir_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MOVE = 1'b1
  } state_e;

  // Wall map, bit 0 = top-left tile, row-major. Column 0 is walled below the
  // top row, plus a horizontal bar on row 7 and a vertical bar on column 10.
  function automatic logic [MAZE_W*MAZE_H-1:0] buildMazeMap();
    logic [MAZE_W*MAZE_H-1:0] m;
    m = '0;
    for (int ty = 0; ty < MAZE_H; ty++) begin
      for (int tx = 0; tx < MAZE_W; tx++) begin
        m[ty*MAZE_W+tx] = ((tx == 0) && (ty != 0)) ||
                          ((ty == 7) && (tx >= 3) && (tx <= 16)) ||
                          ((tx == 10) && (ty >= 2) && (ty <= 5));
      end
    end
    return m;
  endfunction

  localparam logic [MAZE_W*MAZE_H-1:0] MAZE_MAP = buildMazeMap();

  // Sprite artwork: a colour gradient over row/column with the bottom-right
  // 8x8 corner transparent. The low two bits are never 2'b11, so only the
  // corner can ever produce the key colour.
  function automatic logic [7:0] spriteTexel(input logic [9:0] addr);
    logic [4:0] row;
    logic [4:0] col;
    row = addr[9:5];
    col = addr[4:0];
    if ((row[4:3] == 2'b11) && (col[4:3] == 2'b11)) begin
      return SPRITE_KEY;
    end
    return {row[4:2], col[4:2], 2'b10};
  endfunction

endpackage

// File: rtl/player_rom.sv
// 1024x8 player sprite ROM with one cycle of read latency.
// Ports: clk_i clock, addr_i {row[4:0], col[4:0]}, data_o registered texel.
module player_rom
  import player_compositor_pkg::*;
(
  input  logic       clk_i,
  input  logic [9:0] addr_i,
  output logic [7:0] data_o
);

  logic [7:0] data_q;

  // Registered read; contents are a pure function of the address.
  always_ff @(posedge clk_i) begin
    data_q <= spriteTexel(addr_i);
  end

  assign data_o = data_q;

endmodule

// File: rtl/player_compositor.sv
// Owns the player's maze position, animates one-tile moves at 1 px per frame,
// blocks moves into walls or off the maze, and overlays the 32x32 sprite onto
// the background stream with a fixed 3-cycle latency.
// Ports: clk/rst (sync, active-high), h_count/v_count raster counters,
// bg_color (BG_LAT cycles behind counts), btn_* level buttons,
// color_out registered pixel, moving, bump pulse, goal_reached.
module player_compositor
  import player_compositor_pkg::*;
#(
  parameter int         BG_LAT    = 1,
  parameter int         START_X   = 1,
  parameter int         START_Y   = 0,
  parameter int         GOAL_X    = 18,
  parameter int         GOAL_Y    = 14,
  parameter logic [7:0] KEY_COLOR = 8'hE3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic [7:0] bg_color,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [7:0] color_out,
  output logic       moving,
  output logic       bump,
  output logic       goal_reached
);

  state_e     state_q;
  dir_e       dir_q;
  logic [4:0] tileX_q, targetX_q, offset_q;
  logic [3:0] tileY_q, targetY_q;
  logic       moving_q, bump_q;

  logic       frameTick;
  logic       reqValid, reqInRange, reqBlocked;
  dir_e       reqDir;
  logic [5:0] candX;
  logic [4:0] candY;
  logic [8:0] mapIdx;

  assign frameTick = (h_count == 10'd0) && (v_count == 10'd0);

  // Button decode with up>down>left>right priority. Stepping off an edge
  // wraps the unsigned candidate past the maze size, so it fails the range
  // check and is treated as a wall.
  always_comb begin
    reqValid = 1'b1;
    reqDir   = DIR_UP;
    candX    = {1'b0, tileX_q};
    candY    = {1'b0, tileY_q};
    if (btn_up) begin
      reqDir = DIR_UP;
      candY  = {1'b0, tileY_q} - 5'd1;
    end else if (btn_down) begin
      reqDir = DIR_DN;
      candY  = {1'b0, tileY_q} + 5'd1;
    end else if (btn_left) begin
      reqDir = DIR_LT;
      candX  = {1'b0, tileX_q} - 6'd1;
    end else if (btn_right) begin
      reqDir = DIR_RT;
      candX  = {1'b0, tileX_q} + 6'd1;
    end else begin
      reqValid = 1'b0;
    end
    reqInRange = (candX < 6'(MAZE_W)) && (candY < 5'(MAZE_H));
    mapIdx     = reqInRange ? (9'(candY) * 9'(MAZE_W) + 9'(candX)) : 9'd0;
    reqBlocked = !reqInRange || MAZE_MAP[mapIdx];
  end

  // Movement FSM; position only changes on frame_tick to avoid tearing.
  always_ff @(posedge clk) begin
    bump_q <= 1'b0;
    if (rst) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_UP;
      tileX_q   <= 5'(START_X);
      tileY_q   <= 4'(START_Y);
      targetX_q <= 5'(START_X);
      targetY_q <= 4'(START_Y);
      offset_q  <= 5'd0;
      moving_q  <= 1'b0;
    end else if (frameTick) begin
      case (state_q)
        ST_IDLE: begin
          if (reqValid) begin
            if (reqBlocked) begin
              bump_q <= 1'b1;
            end else begin
              dir_q     <= reqDir;
              targetX_q <= candX[4:0];
              targetY_q <= candY[3:0];
              offset_q  <= 5'd0;
              moving_q  <= 1'b1;
              state_q   <= ST_MOVE;
            end
          end
        end
        ST_MOVE: begin
          if (offset_q == 5'd31) begin
            tileX_q  <= targetX_q;
            tileY_q  <= targetY_q;
            offset_q <= 5'd0;
            moving_q <= 1'b0;
            state_q  <= ST_IDLE;
          end else begin
            offset_q <= offset_q + 5'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic [9:0] baseX, baseY, px, py;

  // Sprite origin in visible-area pixels; offset is zero whenever idle.
  always_comb begin
    baseX = {tileX_q, 5'd0};
    baseY = {1'b0, tileY_q, 5'd0};
    px    = baseX;
    py    = baseY;
    case (dir_q)
      DIR_LT:  px = baseX - 10'(offset_q);
      DIR_RT:  px = baseX + 10'(offset_q);
      DIR_UP:  py = baseY - 10'(offset_q);
      default: py = baseY + 10'(offset_q);
    endcase
  end

  logic       visible_d, hit_d;
  logic [9:0] relH, relV, dx, dy, addr_d;

  // Hit test; relH>=px / relV>=py guard the unsigned differences so a
  // wrapped subtraction can never look like a small in-sprite offset.
  always_comb begin
    visible_d = (h_count >= 10'(H_VIS0)) && (h_count <= 10'(H_VIS1)) &&
                (v_count >= 10'(V_VIS0)) && (v_count <= 10'(V_VIS1));
    relH   = h_count - 10'(H_VIS0);
    relV   = v_count - 10'(V_VIS0);
    dx     = relH - px;
    dy     = relV - py;
    hit_d  = visible_d && (relH >= px) && (dx < 10'(TILE)) &&
             (relV >= py) && (dy < 10'(TILE));
    addr_d = {dy[4:0], dx[4:0]};
  end

  logic       hit1_q, visible1_q, hit2_q, visible2_q;
  logic [9:0] addr_q;
  logic [7:0] romData, color_q, bgAligned;

  player_rom uRom (
    .clk_i (clk),
    .addr_i(addr_q),
    .data_o(romData)
  );

  // Stage 1 registers the hit test and ROM address; stage 2 runs alongside
  // the ROM read so flags stay aligned with romData.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit1_q     <= 1'b0;
      visible1_q <= 1'b0;
      addr_q     <= 10'd0;
      hit2_q     <= 1'b0;
      visible2_q <= 1'b0;
    end else begin
      hit1_q     <= hit_d;
      visible1_q <= visible_d;
      addr_q     <= addr_d;
      hit2_q     <= hit1_q;
      visible2_q <= visible1_q;
    end
  end

  // Background is delayed by 2-BG_LAT so it lands alongside the ROM data.
  generate
    if (BG_LAT >= 2) begin : gBgDirect
      assign bgAligned = bg_color;
    end else if (BG_LAT == 1) begin : gBgOne
      logic [7:0] bgDly_q;
      always_ff @(posedge clk) begin
        if (rst) bgDly_q <= 8'd0;
        else     bgDly_q <= bg_color;
      end
      assign bgAligned = bgDly_q;
    end else begin : gBgTwo
      logic [7:0] bgDlyA_q, bgDlyB_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          bgDlyA_q <= 8'd0;
          bgDlyB_q <= 8'd0;
        end else begin
          bgDlyA_q <= bg_color;
          bgDlyB_q <= bgDlyA_q;
        end
      end
      assign bgAligned = bgDlyB_q;
    end
  endgenerate

  // Final mux: blank outside the visible area, key colour shows background.
  always_ff @(posedge clk) begin
    if (rst) begin
      color_q <= 8'd0;
    end else if (!visible2_q) begin
      color_q <= 8'd0;
    end else if (hit2_q && (romData != KEY_COLOR)) begin
      color_q <= romData;
    end else begin
      color_q <= bgAligned;
    end
  end

  assign color_out    = color_q;
  assign moving       = moving_q;
  assign bump         = bump_q;
  assign goal_reached = (tileX_q == 5'(GOAL_X)) && (tileY_q == 4'(GOAL_Y));

endmodule

// File: tb/tb_player_compositor.sv
// Directed bench for player_compositor. Raster counters are driven directly
// so a "frame" is just a one-cycle (0,0) tick. Three instances with
// BG_LAT = 0, 1, 2 share stimulus; the bench supplies each with an
// appropriately delayed background stream.
module tb_player_compositor;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hCount, vCount;
  logic [7:0] bgNow, bgDly1, bgDly2;
  logic       btnUp, btnDown, btnLeft, btnRight;
  logic [7:0] color0, color1, color2;
  logic       moving0, moving1, moving2;
  logic       bump0, bump1, bump2;
  logic       goal0, goal1, goal2;
  int         totalChecks = 0;
  int         badChecks   = 0;
  int         movingFrames;

  always #5 clk = ~clk;

  // Background as seen by the BG_LAT=1 and BG_LAT=2 instances.
  always @(posedge clk) begin
    bgDly1 <= bgNow;
    bgDly2 <= bgDly1;
  end

  player_compositor #(.BG_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .h_count(hCount), .v_count(vCount), .bg_color(bgNow),
    .btn_up(btnUp), .btn_down(btnDown), .btn_left(btnLeft), .btn_right(btnRight),
    .color_out(color0), .moving(moving0), .bump(bump0), .goal_reached(goal0));

  player_compositor #(.BG_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .h_count(hCount), .v_count(vCount), .bg_color(bgDly1),
    .btn_up(btnUp), .btn_down(btnDown), .btn_left(btnLeft), .btn_right(btnRight),
    .color_out(color1), .moving(moving1), .bump(bump1), .goal_reached(goal1));

  player_compositor #(.BG_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .h_count(hCount), .v_count(vCount), .bg_color(bgDly2),
    .btn_up(btnUp), .btn_down(btnDown), .btn_left(btnLeft), .btn_right(btnRight),
    .color_out(color2), .moving(moving2), .bump(bump2), .goal_reached(goal2));

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s got=%02h expected=%02h", tag, got, exp);
    end
  endtask

  // Drive counts/bg for one cycle; returns 1 time unit after the edge.
  task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v, input logic [7:0] bg);
    hCount = h;
    vCount = v;
    bgNow  = bg;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(10'd5, 10'd600, 8'h55);
  endtask

  task automatic frameTick();
    applyStimulus(10'd0, 10'd0, 8'h55);
  endtask

  // Target pixel surrounded by blank pixels: must appear exactly 3 cycles on.
  task automatic checkPixel(input string tag, input logic [9:0] h, input logic [9:0] v,
                            input logic [7:0] bg, input logic [7:0] exp);
    idle();
    applyStimulus(h, v, bg);
    idle();
    checkOutput({tag, "_early"}, color1, 8'h00);
    idle();
    checkOutput({tag, "_lat0"}, color0, exp);
    checkOutput({tag, "_lat1"}, color1, exp);
    checkOutput({tag, "_lat2"}, color2, exp);
    idle();
    checkOutput({tag, "_late"}, color1, 8'h00);
  endtask

  task automatic pressMove(input logic u, input logic d, input logic l, input logic r);
    btnUp = u; btnDown = d; btnLeft = l; btnRight = r;
    frameTick();
    btnUp = 0; btnDown = 0; btnLeft = 0; btnRight = 0;
    idle();
    repeat (32) begin
      frameTick();
      idle();
    end
  endtask

  task automatic tryBlocked(input string tag, input logic u, input logic d,
                            input logic l, input logic r);
    btnUp = u; btnDown = d; btnLeft = l; btnRight = r;
    frameTick();
    checkOutput({tag, "_bumpHigh"}, {7'd0, bump1}, 8'd1);
    btnUp = 0; btnDown = 0; btnLeft = 0; btnRight = 0;
    idle();
    checkOutput({tag, "_bumpLow"}, {7'd0, bump1}, 8'd0);
    checkOutput({tag, "_moving"}, {7'd0, moving1}, 8'd0);
  endtask

  initial begin
    rst = 1'b1;
    btnUp = 0; btnDown = 0; btnLeft = 0; btnRight = 0;
    hCount = 10'd5; vCount = 10'd600; bgNow = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstColor0", color0, 8'h00);
    checkOutput("rstColor2", color2, 8'h00);
    checkOutput("rstMoving", {7'd0, moving1}, 8'd0);
    checkOutput("rstBump", {7'd0, bump1}, 8'd0);
    checkOutput("rstGoal", {7'd0, goal1}, 8'd0);
    rst = 1'b0;

    $display("[TB] reset state and first frame at tile (1,0)");
    frameTick();
    idle();
    checkOutput("frame1Moving", {7'd0, moving1}, 8'd0);
    checkOutput("frame1Bump", {7'd0, bump1}, 8'd0);
    checkPixel("spriteOrigin", 10'd176, 10'd31, 8'h47, 8'h02);
    checkPixel("bgLeftOfSprite", 10'd144, 10'd31, 8'h47, 8'h47);
    checkPixel("spriteInner", 10'd185, 10'd36, 8'h47, 8'h2A);
    checkPixel("spriteRightCol", 10'd207, 10'd31, 8'h47, 8'h1E);
    checkPixel("pastSpriteRight", 10'd208, 10'd31, 8'h47, 8'h47);
    checkPixel("invisibleLeft", 10'd100, 10'd50, 8'h47, 8'h00);
    checkPixel("invisibleRight", 10'd784, 10'd100, 8'h47, 8'h00);
    checkPixel("lastVisibleCol", 10'd783, 10'd100, 8'h47, 8'h47);

    $display("[TB] off-maze up from row 0");
    tryBlocked("offTop", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] move down from (1,0)");
    btnDown = 1'b1;
    frameTick();
    btnDown = 1'b0;
    idle();
    checkOutput("downEntryMoving", {7'd0, moving1}, 8'd1);
    checkPixel("downFrame0Top", 10'd176, 10'd31, 8'h33, 8'h02);
    movingFrames = 0;
    for (int k = 1; k <= 31; k++) begin
      frameTick();
      idle();
      if (moving1) movingFrames++;
      if (k == 15) begin
        checkPixel("downFrame15Top", 10'd176, 10'd46, 8'h33, 8'h02);
        checkPixel("downFrame15Above", 10'd176, 10'd45, 8'h33, 8'h33);
      end
    end
    checkOutput("downMovingFrames", 8'(movingFrames), 8'd31);
    frameTick();
    idle();
    checkOutput("downDoneMoving", {7'd0, moving1}, 8'd0);
    checkPixel("tile11Top", 10'd176, 10'd63, 8'h33, 8'h02);
    checkPixel("tile11Above", 10'd176, 10'd62, 8'h33, 8'h33);

    $display("[TB] left into wall at (0,1)");
    tryBlocked("wallLeft", 1'b0, 1'b0, 1'b1, 1'b0);
    checkPixel("afterBumpTile", 10'd176, 10'd63, 8'h33, 8'h02);

    $display("[TB] up and right together at (1,1)");
    pressMove(1'b1, 1'b0, 1'b0, 1'b1);
    checkPixel("upChosen", 10'd176, 10'd31, 8'h66, 8'h02);
    checkPixel("rightIgnored", 10'd208, 10'd63, 8'h66, 8'h66);

    $display("[TB] key colour shows background on all latencies");
    checkPixel("keyPixel", 10'd200, 10'd55, 8'h1C, 8'h1C);

    $display("[TB] reset mid-move");
    btnDown = 1'b1;
    frameTick();
    btnDown = 1'b0;
    idle();
    repeat (15) begin
      frameTick();
      idle();
    end
    repeat (3) applyStimulus(10'd144, 10'd400, 8'h77);
    checkOutput("preRstColor", color1, 8'h77);
    rst = 1'b1;
    applyStimulus(10'd144, 10'd400, 8'h77);
    checkOutput("midRstColor", color1, 8'h00);
    checkOutput("midRstMoving", {7'd0, moving1}, 8'd0);
    rst = 1'b0;
    checkPixel("postRstTop", 10'd176, 10'd31, 8'h66, 8'h02);
    checkPixel("postRstRow15", 10'd176, 10'd46, 8'h66, 8'h62);

    $display("[TB] walk to the goal tile");
    repeat (17) pressMove(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (13) pressMove(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("at1813Goal", {7'd0, goal1}, 8'd0);
    pressMove(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("at1814Goal", {7'd0, goal1}, 8'd1);
    checkPixel("goalSpriteTop", 10'd720, 10'd479, 8'h21, 8'h02);
    checkPixel("goalBottomRow", 10'd720, 10'd510, 8'h21, 8'hE2);
    checkPixel("goalKeyCorner", 10'd751, 10'd510, 8'h21, 8'h21);
    pressMove(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("at1914Goal", {7'd0, goal1}, 8'd0);
    tryBlocked("offRight", 1'b0, 1'b0, 1'b0, 1'b1);
    tryBlocked("offBottom", 1'b0, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
